// File: rtl/board_state.sv
// board_state: 8x8 chess board register file driven flat into the VGA pixel generator.
// Define BOARD_STATE_HIGHLIGHT_EN to mark the squares of the last move via bit 4.
module board_state #(
    parameter int PIECE_W         = 5,
    parameter bit APPLY_IN_VBLANK = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_game,
    input  logic                    vblank,
    input  logic                    move_valid,
    input  logic [5:0]              move_from,
    input  logic [5:0]              move_to,
    output logic                    move_ready,
    output logic                    move_done,
    output logic                    move_err,
    output logic                    capture_valid,
    output logic [PIECE_W-1:0]      capture_piece,
    output logic [64*PIECE_W-1:0]   board
);

    localparam logic [1:0] S_INIT    = 2'd0;
    localparam logic [1:0] S_IDLE    = 2'd1;
    localparam logic [1:0] S_WAIT_VB = 2'd2;
    localparam logic [1:0] S_APPLY   = 2'd3;

    logic [1:0]         r_state;
    logic [5:0]         r_idx;
    logic [5:0]         r_from;
    logic [5:0]         r_to;
    logic [PIECE_W-2:0] r_src;
    logic               r_done;
    logic               r_err;
    logic               r_cap_valid;
    logic [PIECE_W-1:0] r_cap_piece;
    logic [PIECE_W-1:0] r_board [0:63];

    logic               w_accept;
    logic               w_reject;
    logic [PIECE_W-2:0] w_src_code;
    logic [PIECE_W-1:0] w_to_code;

    // Start position: black back rank on row 0, white back rank on row 7.
    function automatic logic [PIECE_W-1:0] start_code(input logic [5:0] idx);
        logic [2:0]         piece;
        logic [PIECE_W-1:0] code;
        case (idx[2:0])
            3'd0, 3'd7: piece = 3'd4;
            3'd1, 3'd6: piece = 3'd2;
            3'd2, 3'd5: piece = 3'd3;
            3'd3:       piece = 3'd5;
            default:    piece = 3'd6;
        endcase
        case (idx[5:3])
            3'd0:    code = {2'b01, piece};
            3'd1:    code = {2'b01, 3'd1};
            3'd6:    code = {2'b00, 3'd1};
            3'd7:    code = {2'b00, piece};
            default: code = '0;
        endcase
        return code;
    endfunction

    assign move_ready = (r_state == S_IDLE) && !new_game;
    assign w_accept   = move_valid && move_ready;
    assign w_src_code = r_board[move_from][PIECE_W-2:0];
    assign w_reject   = (move_from == move_to) || (w_src_code[2:0] == 3'd0);
    assign w_to_code  = r_board[r_to];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                r_board[i] <= '0;
            end
            r_state     <= S_INIT;
            r_idx       <= 6'd0;
            r_from      <= 6'd0;
            r_to        <= 6'd0;
            r_src       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cap_valid <= 1'b0;
            r_cap_piece <= '0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cap_valid <= 1'b0;
            if (new_game) begin
                // Any pending move is silently dropped; INIT rewrites every square.
                r_state <= S_INIT;
                r_idx   <= 6'd0;
            end else begin
                case (r_state)
                    S_INIT: begin
                        r_board[r_idx] <= start_code(r_idx);
                        r_idx          <= r_idx + 6'd1;
                        if (r_idx == 6'd63) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_IDLE: begin
                        if (w_accept) begin
                            r_from <= move_from;
                            r_to   <= move_to;
                            r_src  <= w_src_code;
                            if (w_reject) begin
                                r_err <= 1'b1;
                            end else if (!APPLY_IN_VBLANK || vblank) begin
                                // Already in blanking: skip the wait state entirely.
                                r_state <= S_APPLY;
                            end else begin
                                r_state <= S_WAIT_VB;
                            end
                        end
                    end
                    S_WAIT_VB: begin
                        if (vblank) begin
                            r_state <= S_APPLY;
                        end
                    end
                    default: begin
`ifdef BOARD_STATE_HIGHLIGHT_EN
                        for (int i = 0; i < 64; i++) begin
                            r_board[i][PIECE_W-1] <= 1'b0;
                        end
                        r_board[r_to]   <= {1'b1, r_src};
                        r_board[r_from] <= {1'b1, {(PIECE_W-1){1'b0}}};
`else
                        r_board[r_to]   <= {1'b0, r_src};
                        r_board[r_from] <= '0;
`endif
                        if (w_to_code[2:0] != 3'd0) begin
                            r_cap_valid <= 1'b1;
                            r_cap_piece <= w_to_code;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign move_done     = r_done;
    assign move_err      = r_err;
    assign capture_valid = r_cap_valid;
    assign capture_piece = r_cap_piece;

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_board
            assign board[gi*PIECE_W +: PIECE_W] = r_board[gi];
        end
    endgenerate

endmodule

// File: tb/tb_board_state.sv
// tb_board_state: directed and randomized move traffic against a square-array reference model.
module tb_board_state;

    logic         clk = 1'b0;
    logic         reset;
    logic         new_game;
    logic         vblank;
    logic         move_valid;
    logic [5:0]   move_from;
    logic [5:0]   move_to;
    logic         move_ready;
    logic         move_done;
    logic         move_err;
    logic         capture_valid;
    logic [4:0]   capture_piece;
    logic [319:0] board;

    int checks = 0;
    int errors = 0;

    logic [4:0] m_board [64];
    logic [4:0] m_cap_piece;

    board_state dut (
        .clk          (clk),
        .reset        (reset),
        .new_game     (new_game),
        .vblank       (vblank),
        .move_valid   (move_valid),
        .move_from    (move_from),
        .move_to      (move_to),
        .move_ready   (move_ready),
        .move_done    (move_done),
        .move_err     (move_err),
        .capture_valid(capture_valid),
        .capture_piece(capture_piece),
        .board        (board)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [319:0] model_flat();
        logic [319:0] f;
        for (int i = 0; i < 64; i++) f[i*5 +: 5] = m_board[i];
        return f;
    endfunction

    task automatic chk_board(input string tag);
        logic [319:0] f;
        int bad;
        f = model_flat();
        bad = 0;
        for (int i = 0; i < 64; i++) if (board[i*5 +: 5] !== f[i*5 +: 5]) bad = i;
        checks++;
        assert (board === f) else begin
            errors++;
            $error("FAIL %s square %0d observed=%0h expected=%0h", tag, bad, board[bad*5 +: 5], f[bad*5 +: 5]);
        end
    endtask

    function automatic logic [4:0] start_sq(input int idx);
        int r;
        int c;
        logic [2:0] p;
        r = idx / 8;
        c = idx % 8;
        case (c)
            0, 7: p = 3'd4;
            1, 6: p = 3'd2;
            2, 5: p = 3'd3;
            3:    p = 3'd5;
            default: p = 3'd6;
        endcase
        if (r == 0) return {2'b01, p};
        if (r == 1) return 5'h09;
        if (r == 6) return 5'h01;
        if (r == 7) return {2'b00, p};
        return 5'h00;
    endfunction

    task automatic model_start();
        for (int i = 0; i < 64; i++) m_board[i] = start_sq(i);
    endtask

    // Wait through an INIT phase, starting at the sample after the edge that entered it.
    task automatic run_init_check(input string tag);
        logic pulse;
        pulse = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk({tag, "_ready_low"}, move_ready, 1'b0);
            pulse = pulse | move_done | move_err;
            tick();
        end
        chk({tag, "_ready_high"}, move_ready, 1'b1);
        chk({tag, "_no_pulse"}, pulse, 1'b0);
        model_start();
        chk_board({tag, "_start_pos"});
        $display("init %s complete at %0t", tag, $time);
    endtask

    // One move: vblank is low for k edges starting at the acceptance edge, high afterwards.
    task automatic do_move(input logic [5:0] f, input logic [5:0] t, input int k);
        logic       reject;
        logic       exp_cap;
        logic [4:0] src;
        logic [4:0] old;
        int         j;
        chk("ready_before_move", move_ready, 1'b1);
        reject = (f == t) || (m_board[f][2:0] == 3'd0);
        move_valid = 1'b1;
        move_from  = f;
        move_to    = t;
        vblank     = (k == 0);
        tick();
        move_valid = 1'b0;
        if (reject) begin
            chk("err_pulse", move_err, 1'b1);
            chk("err_no_done", move_done, 1'b0);
            chk("err_ready", move_ready, 1'b1);
            chk_board("err_board_unchanged");
            tick();
            chk("err_pulse_end", move_err, 1'b0);
            $display("move %0d->%0d rejected", f, t);
            return;
        end
        chk("no_err", move_err, 1'b0);
        for (j = 1; j <= 200; j++) begin
            vblank = (j >= k);
            tick();
            if (move_done) break;
            if (j == k) chk_board("no_early_write");
        end
        chk("done_latency", j, k + 1);
        src = m_board[f];
        old = m_board[t];
        exp_cap = (old[2:0] != 3'd0);
        if (exp_cap) m_cap_piece = old;
`ifdef BOARD_STATE_HIGHLIGHT_EN
        for (int i = 0; i < 64; i++) m_board[i][4] = 1'b0;
        m_board[t] = {1'b1, src[3:0]};
        m_board[f] = 5'h10;
`else
        m_board[t] = {1'b0, src[3:0]};
        m_board[f] = 5'h00;
`endif
        chk("capture_valid", capture_valid, exp_cap);
        chk("capture_piece", capture_piece, m_cap_piece);
        chk_board("board_after_move");
        tick();
        chk("done_pulse_end", move_done, 1'b0);
        chk("capture_pulse_end", capture_valid, 1'b0);
        $display("move %0d->%0d done latency=%0d capture=%0d piece=%0h", f, t, j, exp_cap, m_cap_piece);
    endtask

    initial begin
        logic [5:0] rf;
        logic [5:0] rt;
        reset = 1'b1; new_game = 1'b0; vblank = 1'b0;
        move_valid = 1'b0; move_from = 6'd0; move_to = 6'd0;
        m_cap_piece = 5'h00;
        for (int i = 0; i < 64; i++) m_board[i] = 5'h00;

        tick();
        tick();
        chk("rst_ready", move_ready, 1'b0);
        chk("rst_done", move_done, 1'b0);
        chk("rst_err", move_err, 1'b0);
        chk("rst_capv", capture_valid, 1'b0);
        chk("rst_capp", capture_piece, 5'h00);
        chk_board("rst_board");
        reset = 1'b0;
        run_init_check("reset");
        chk("sq0_black_rook", board[0 +: 5], 5'h0C);
        chk("sq60_white_king", board[300 +: 5], 5'h06);
        chk("sq27_empty", board[135 +: 5], 5'h00);

        // e2-e4 held off by a long active-video period.
        do_move(6'd52, 6'd36, 101);
`ifdef BOARD_STATE_HIGHLIGHT_EN
        chk("e4_sq36", board[180 +: 5], 5'h11);
        chk("e4_sq52", board[260 +: 5], 5'h10);
`else
        chk("e4_sq36", board[180 +: 5], 5'h01);
        chk("e4_sq52", board[260 +: 5], 5'h00);
`endif

        do_move(6'd35, 6'd20, 0);
        do_move(6'd12, 6'd12, 0);

        // White pawn onto 11 (capturing a black pawn), then the black queen takes it.
        do_move(6'd51, 6'd11, 0);
        do_move(6'd3, 6'd11, 2);
        chk("qx_capture_piece", capture_piece, 5'h01);
`ifdef BOARD_STATE_HIGHLIGHT_EN
        chk("qx_sq11", board[55 +: 5], 5'h1D);
`else
        chk("qx_sq11", board[55 +: 5], 5'h0D);
`endif

        for (int n = 0; n < 30; n++) begin
            rf = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                for (int tries = 0; tries < 64 && m_board[rf][2:0] == 3'd0; tries++)
                    rf = 6'($urandom_range(0, 63));
            end
            rt = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) rt = rf;
            do_move(rf, rt, int'($urandom_range(0, 5)));
        end

        // new_game while a move waits for blanking.
        model_start();
        new_game = 1'b1; vblank = 1'b1;
        tick();
        new_game = 1'b0;
        run_init_check("ng_pre");
        vblank = 1'b0;
        move_valid = 1'b1; move_from = 6'd52; move_to = 6'd44;
        tick();
        move_valid = 1'b0;
        tick();
        tick();
        chk("wait_vb_no_done", move_done, 1'b0);
        new_game = 1'b1; vblank = 1'b1;
        tick();
        new_game = 1'b0;
        run_init_check("ng_wait_vb");

        // new_game and move_valid together: the move is not taken.
        new_game = 1'b1; move_valid = 1'b1; move_from = 6'd52; move_to = 6'd36;
        #1;
        chk("ng_blocks_ready", move_ready, 1'b0);
        @(posedge clk);
        #1;
        new_game = 1'b0; move_valid = 1'b0;
        run_init_check("ng_with_move");

`ifdef BOARD_STATE_HIGHLIGHT_EN
        do_move(6'd62, 6'd45, 0);
        do_move(6'd6, 6'd21, 0);
        for (int i = 0; i < 64; i++) begin
            if (i == 6)       chk("hl_sq6", board[i*5 +: 5], 5'h10);
            else if (i == 21) chk("hl_sq21", board[i*5 +: 5], 5'h1A);
            else              chk("hl_clear", board[i*5 + 4], 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
